// File: rtl/compare_arbiter.sv
// compare_arbiter: shares one compare unit among NUM_REQ requesters and returns tagged results.
// Define CMP_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module compare_arbiter #(
  parameter int DATA_WIDTH = 20,
  parameter int NUM_REQ    = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          cmp_en,
  output logic [DATA_WIDTH-1:0]         cmp_a,
  output logic [DATA_WIDTH-1:0]         cmp_b,
  input  logic [DATA_WIDTH-1:0]         cmp_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] opA_q;
  logic [DATA_WIDTH-1:0] opB_q;
  logic [ID_W-1:0]       id_q;
  logic                  cmpEn_q;
  logic                  rspValid_q;
  logic [ID_W-1:0]       rspId_q;
  logic [DATA_WIDTH-1:0] rspResult_q;

  logic                  anyValid;
  logic [ID_W-1:0]       winIdx;
  logic [DATA_WIDTH-1:0] winA;
  logic [DATA_WIDTH-1:0] winB;
  logic                  acceptSlot;
  logic                  accept;

`ifdef CMP_ARB_RR_EN
  // ptr_q holds the index searched first, so a reset value of 0 gives index 0 top priority.
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       ptr_d;
`endif

  always_comb begin
    int idx;
    idx      = 0;
    anyValid = 1'b0;
    winIdx   = '0;
    winA     = '0;
    winB     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CMP_ARB_RR_EN
      idx = (int'(ptr_q) + k) % NUM_REQ;
`else
      idx = k;
`endif
      if (!anyValid && req_valid[idx]) begin
        anyValid = 1'b1;
        winIdx   = ID_W'(idx);
        winA     = req_a[idx*DATA_WIDTH +: DATA_WIDTH];
        winB     = req_b[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A new request may only be taken when the response slot is free or being drained this cycle.
  assign acceptSlot = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept     = !rst && anyValid && acceptSlot;
  assign req_ready  = accept ? (NUM_REQ'(1) << winIdx) : '0;

`ifdef CMP_ARB_RR_EN
  assign ptr_d = (winIdx == ID_W'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opA_q       <= '0;
      opB_q       <= '0;
      id_q        <= '0;
      cmpEn_q     <= 1'b0;
      rspValid_q  <= 1'b0;
      rspId_q     <= '0;
      rspResult_q <= '0;
`ifdef CMP_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            opA_q   <= winA;
            opB_q   <= winB;
            id_q    <= winIdx;
            cmpEn_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          rspResult_q <= cmp_result;
          rspId_q     <= id_q;
          rspValid_q  <= 1'b1;
          cmpEn_q     <= 1'b0;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            if (accept) begin
              opA_q   <= winA;
              opB_q   <= winB;
              id_q    <= winIdx;
              cmpEn_q <= 1'b1;
              state_q <= ISSUE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          cmpEn_q    <= 1'b0;
          rspValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
`ifdef CMP_ARB_RR_EN
      if (accept) begin
        ptr_q <= ptr_d;
      end
`endif
    end
  end

  assign cmp_en     = cmpEn_q;
  assign cmp_a      = opA_q;
  assign cmp_b      = opB_q;
  assign rsp_valid  = rspValid_q;
  assign rsp_id     = rspId_q;
  assign rsp_result = rspResult_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed self-checking bench for compare_arbiter with a behavioural compare unit attached.
module tb_compare_arbiter;

  localparam int DW = 20;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    reqValid;
  logic [NR*DW-1:0] reqA;
  logic [NR*DW-1:0] reqB;
  logic [NR-1:0]    reqReady;
  logic             cmpEn;
  logic [DW-1:0]    cmpA;
  logic [DW-1:0]    cmpB;
  logic [DW-1:0]    cmpResult;
  logic             rspValid;
  logic             rspReady;
  logic [IW-1:0]    rspId;
  logic [DW-1:0]    rspResult;

  int assertCount;
  int failCount;
  int order[6];
  int stallId;
  int nextId;

  compare_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (reqValid),
    .req_a      (reqA),
    .req_b      (reqB),
    .req_ready  (reqReady),
    .cmp_en     (cmpEn),
    .cmp_a      (cmpA),
    .cmp_b      (cmpB),
    .cmp_result (cmpResult),
    .rsp_valid  (rspValid),
    .rsp_ready  (rspReady),
    .rsp_id     (rspId),
    .rsp_result (rspResult)
  );

  // Compare unit: bit0 = a<b, bit1 = a>=b, unsigned.
  assign cmpResult = {{(DW-2){1'b0}}, (cmpA >= cmpB), (cmpA < cmpB)};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NR-1:0] valid);
    reqValid = valid;
    #1;
  endtask

  task automatic setOperands(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
    reqA[idx*DW +: DW] = a;
    reqB[idx*DW +: DW] = b;
  endtask

  // One isolated transaction from IDLE with rsp_ready held high.
  task automatic doTxn(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] expRes);
    setOperands(idx, a, b);
    applyStimulus(NR'(1) << idx);
    checkOutput("txn_ready", 32'(reqReady), 32'(NR'(1) << idx));
    step();
    applyStimulus('0);
    checkOutput("txn_cmp_en", 32'(cmpEn), 32'd1);
    checkOutput("txn_cmp_a", 32'(cmpA), 32'(a));
    checkOutput("txn_cmp_b", 32'(cmpB), 32'(b));
    step();
    checkOutput("txn_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("txn_rsp_id", 32'(rspId), 32'(idx));
    checkOutput("txn_rsp_result", 32'(rspResult), 32'(expRes));
    step();
    checkOutput("txn_idle_valid", 32'(rspValid), 32'd0);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
`ifdef CMP_ARB_RR_EN
    order = '{0, 1, 2, 3, 0, 1};
    stallId = 1;
    nextId  = 2;
`else
    order = '{0, 0, 0, 0, 0, 0};
    stallId = 0;
    nextId  = 0;
`endif
    rst      = 1'b1;
    reqValid = '1;
    reqA     = '0;
    reqB     = '0;
    rspReady = 1'b0;

    // Reset held for two cycles with every requester pending.
    step();
    step();
    checkOutput("rst_req_ready", 32'(reqReady), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rst_cmp_en", 32'(cmpEn), 32'd0);
    checkOutput("rst_cmp_a", 32'(cmpA), 32'd0);
    checkOutput("rst_cmp_b", 32'(cmpB), 32'd0);
    checkOutput("rst_rsp_result", 32'(rspResult), 32'd0);
    rst      = 1'b0;
    rspReady = 1'b1;
    applyStimulus('0);
    checkOutput("idle_no_req", 32'(reqReady), 32'd0);

    // Single transactions, including equal and unsigned-extreme operands.
    doTxn(0, 20'd5, 20'd9, 20'h00001);
    doTxn(2, 20'd9, 20'd9, 20'h00002);
    doTxn(1, 20'hFFFFF, 20'd0, 20'h00002);
    doTxn(3, 20'd0, 20'd1, 20'h00001);

    // All requesters pending, back-to-back grants every two cycles.
    for (int i = 0; i < NR; i++) setOperands(i, DW'(i), 20'd2);
    applyStimulus('1);
    checkOutput("b2b_first_ready", 32'(reqReady), 32'(NR'(1) << order[0]));
    for (int g = 0; g < 5; g++) begin
      step();
      checkOutput("b2b_cmp_en", 32'(cmpEn), 32'd1);
      checkOutput("b2b_cmp_a", 32'(cmpA), 32'(order[g]));
      checkOutput("b2b_issue_ready", 32'(reqReady), 32'd0);
      step();
      checkOutput("b2b_rsp_id", 32'(rspId), 32'(order[g]));
      checkOutput("b2b_rsp_result", 32'(rspResult), (order[g] < 2) ? 32'd1 : 32'd2);
      if (g < 4) checkOutput("b2b_next_ready", 32'(reqReady), 32'(NR'(1) << order[g+1]));
    end
    applyStimulus('0);
    step();
    checkOutput("b2b_idle", 32'(rspValid), 32'd0);

    // Consumer stall for several cycles in RESP.
    rspReady = 1'b0;
    applyStimulus('1);
    checkOutput("stall_first_ready", 32'(reqReady), 32'(NR'(1) << stallId));
    step();
    step();
    checkOutput("stall_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("stall_rsp_id", 32'(rspId), 32'(stallId));
    for (int c = 0; c < 5; c++) begin
      step();
      checkOutput("stall_hold_valid", 32'(rspValid), 32'd1);
      checkOutput("stall_hold_id", 32'(rspId), 32'(stallId));
      checkOutput("stall_hold_result", 32'(rspResult), 32'd1);
      checkOutput("stall_hold_ready", 32'(reqReady), 32'd0);
      checkOutput("stall_hold_cmp_en", 32'(cmpEn), 32'd0);
    end
    rspReady = 1'b1;
    #1;
    checkOutput("stall_release_ready", 32'(reqReady), 32'(NR'(1) << nextId));
    step();
    checkOutput("stall_next_cmp_en", 32'(cmpEn), 32'd1);
    checkOutput("stall_next_cmp_a", 32'(cmpA), 32'(nextId));
    applyStimulus('0);
    step();
    step();
    checkOutput("stall_drain_idle", 32'(rspValid), 32'd0);

    // Reset while req1 is in ISSUE drops it entirely.
    setOperands(1, 20'd7, 20'd3);
    applyStimulus(4'b0010);
    checkOutput("rstmid_ready", 32'(reqReady), 32'b0010);
    step();
    checkOutput("rstmid_cmp_en", 32'(cmpEn), 32'd1);
    rst = 1'b1;
    applyStimulus('0);
    step();
    checkOutput("rstmid_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rstmid_cmp_en_clr", 32'(cmpEn), 32'd0);
    checkOutput("rstmid_cmp_a_clr", 32'(cmpA), 32'd0);
    rst = 1'b0;
    step();
    checkOutput("rstmid_no_rsp", 32'(rspValid), 32'd0);
    applyStimulus('1);
    checkOutput("rstmid_grant0", 32'(reqReady), 32'b0001);
    step();
    checkOutput("rstmid_cmp_a0", 32'(cmpA), 32'd0);
    applyStimulus('0);
    step();
    checkOutput("rstmid_rsp_id0", 32'(rspId), 32'd0);
    checkOutput("rstmid_rsp_res0", 32'(rspResult), 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
